// File: rtl/frac_clk_div_if.sv
// Configuration and status bundle for the fractional clock divider.
// load is a one-cycle strobe; ready/cfg_err report the validity of the active configuration.
interface frac_clk_div_if #(
   parameter int CNT_W = 32
);
   logic [CNT_W-1:0] freq_in;
   logic [CNT_W-1:0] freq_out;
   logic             mode;
   logic             load;
   logic             enable;
   logic             clk_out;
   logic             ready;
   logic             cfg_err;

   // Handshake: the master holds load high for exactly one clk_in cycle; freq_in/freq_out/mode are
   // sampled on that edge, and from the next cycle ready (or cfg_err) reflects the new configuration.
   modport master (
      output freq_in, freq_out, mode, load, enable,
      input  clk_out, ready, cfg_err
   );

   modport slave (
      input  freq_in, freq_out, mode, load, enable,
      output clk_out, ready, cfg_err
   );
endinterface

// File: rtl/frac_clk_div.sv
// Fractional clock divider: phase accumulator producing freq_out events per freq_in clk_in cycles,
// emitted either as one-cycle pulses (mode 0) or as a square wave (mode 1).
module frac_clk_div #(
   parameter int CNT_W        = 32,
   parameter int DEF_FREQ_IN  = 50,
   parameter int DEF_FREQ_OUT = 9,
   parameter int DEF_MODE     = 0
) (
   input logic            clk_in,
   input logic            reset_,
   frac_clk_div_if.slave  bus
);

   // Mode 1 needs two events per output period, so its requirement is evaluated one bit wider.
   function automatic logic cfg_ok(input logic [CNT_W-1:0] fi,
                                   input logic [CNT_W-1:0] fo,
                                   input logic             m);
      logic [CNT_W:0] need;
      need = m ? {fo, 1'b0} : {1'b0, fo};
      return (fi != '0) && (fo != '0) && (need <= {1'b0, fi});
   endfunction

   localparam logic [CNT_W-1:0] DEF_FI = CNT_W'(DEF_FREQ_IN);
   localparam logic [CNT_W-1:0] DEF_FO = CNT_W'(DEF_FREQ_OUT);
   localparam logic             DEF_M  = DEF_MODE[0];
   localparam logic             DEF_OK = cfg_ok(DEF_FI, DEF_FO, DEF_M);

   logic [CNT_W-1:0] fi_q;
   logic [CNT_W-1:0] fo_q;
   logic             mode_q;
   logic [CNT_W:0]   acc_q;
   logic             clk_q;
   logic             ready_q;

   logic [CNT_W:0]   step;
   logic [CNT_W:0]   sum;
   logic [CNT_W:0]   acc_nxt;
   logic             evt;

   always_comb begin
      step    = mode_q ? {fo_q, 1'b0} : {1'b0, fo_q};
      sum     = acc_q + step;
      evt     = (sum >= {1'b0, fi_q});
      acc_nxt = evt ? (sum - {1'b0, fi_q}) : sum;
   end

   always_ff @(posedge clk_in or negedge reset_) begin
      if (!reset_) begin
         fi_q    <= DEF_FI;
         fo_q    <= DEF_FO;
         mode_q  <= DEF_M;
         acc_q   <= '0;
         clk_q   <= 1'b0;
         ready_q <= DEF_OK;
      end else if (bus.load) begin
         fi_q    <= bus.freq_in;
         fo_q    <= bus.freq_out;
         mode_q  <= bus.mode;
         acc_q   <= '0;
         clk_q   <= 1'b0;
         ready_q <= cfg_ok(bus.freq_in, bus.freq_out, bus.mode);
      end else if (!ready_q) begin
         acc_q <= '0;
         clk_q <= 1'b0;
      end else if (bus.enable) begin
         acc_q <= acc_nxt;
         clk_q <= mode_q ? (clk_q ^ evt) : evt;
      end else if (!mode_q) begin
         // Holding: pulses are suppressed, while a square wave keeps its current level.
         clk_q <= 1'b0;
      end
   end

   assign bus.clk_out = clk_q;
   assign bus.ready   = ready_q;
   assign bus.cfg_err = ~ready_q;

endmodule

// File: doc/frac_clk_div.md
FRAC_CLK_DIV -- requirements
Module: frac_clk_div

Interface
REQ-001 Parameter CNT_W, default 32, width of frequency configuration words.
REQ-002 Parameter DEF_FREQ_IN, default 50, reset value of the input-frequency register (Hz, integer).
REQ-003 Parameter DEF_FREQ_OUT, default 9, reset value of the output-frequency register (Hz, integer).
REQ-004 Parameter DEF_MODE, default 0, reset value of the mode register (0 = pulse, 1 = square).
REQ-005 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_  input  1  asynchronous, active-low reset.
REQ-007 freq_in  input  CNT_W  source frequency value, sampled on load.
REQ-008 freq_out  input  CNT_W  target frequency value, sampled on load.
REQ-009 mode  input  1  output mode, sampled on load.
REQ-010 load  input  1  single-cycle configuration strobe.
REQ-011 enable  input  1  run/hold control.
REQ-012 clk_out  output  1  registered divided output.
REQ-013 ready  output  1  high while the active configuration is valid.
REQ-014 cfg_err  output  1  high while the active configuration is invalid.

Function
REQ-015 Configuration validity: freq_in != 0; freq_out != 0; mode 0 needs freq_out <= freq_in; mode 1 needs 2*freq_out <= freq_in, evaluated in CNT_W+1 bits with no overflow.
REQ-016 Rising edge with load=1: latch freq_in, freq_out and mode; clear the accumulator to 0; set clk_out to 0; set ready to the validity result; set cfg_err to its inverse. Load takes priority over enable.
REQ-017 Load is accepted in any state, including mid-run; the previous phase is discarded with no partial pulse.
REQ-018 Step = freq_out (mode 0) or 2*freq_out (mode 1). The accumulator is CNT_W+1 bits wide and never overflows.
REQ-019 Rising edge with load=0, ready=1, enable=1: sum = acc + step; if sum >= freq_in then acc <= sum - freq_in and event=1, else acc <= sum and event=0.
REQ-020 Mode 0 output: clk_out <= event, giving a one-cycle high pulse per event.
REQ-021 Mode 1 output: clk_out <= clk_out XOR event, giving a square wave at the average freq_out.
REQ-022 Long-run average: exactly freq_out output periods per freq_in clk_in cycles. Per-period jitter is at most 1 clk_in cycle.
REQ-023 enable=0 with ready=1: accumulator holds. Mode 0 drives clk_out to 0. Mode 1 holds clk_out. Resuming continues from the held phase.
REQ-024 ready=0: accumulator is held at 0 and clk_out is held at 0 until a load with a valid configuration.
REQ-025 freq_out == freq_in in mode 0: an event occurs every enabled cycle, so clk_out stays high continuously.
REQ-026 freq_in == 2*freq_out in mode 1: clk_out toggles every enabled cycle.
REQ-027 ready and cfg_err are mutually exclusive and change only on load or reset.

Reset
REQ-028 While reset_ is low, asynchronously: accumulator = 0; clk_out = 0; configuration registers = DEF_FREQ_IN / DEF_FREQ_OUT / DEF_MODE; ready/cfg_err reflect the validity of those defaults.
REQ-029 After reset_ deasserts, the block runs from the default configuration when enable=1, with no load required.
REQ-030 Reset asserted mid-run aborts any pulse or high phase; clk_out goes low immediately, without waiting for a clock edge.

Verification
REQ-031 Defaults (50/9, mode 0), enable=1 after reset -> clk_out high for one cycle following edges 6, 12, 17, 23, 28, 34, 39, 45, 50; exactly 9 pulses per 50 cycles, repeating.
REQ-032 Load 10/5 mode 0, then load 10/3 mode 1 -> first setting gives a pulse every 2nd cycle; second gives clk_out toggling at edges 2, 4, 5, 7, 9, 10 (period average 10/3 cycles); ready=1 throughout.
REQ-033 Load freq_out=0, then load 8/5 in mode 1 -> first gives cfg_err=1, ready=0, clk_out held 0; second (2*5 > 8) also gives cfg_err=1; a subsequent load of 8/4 mode 1 gives ready=1 and clk_out toggling every cycle.
REQ-034 Defaults running, enable low for 7 cycles after edge 10 -> mode 0 clk_out 0 during the hold; pulse sequence resumes shifted by exactly 7 cycles (next pulse at edge 19).
REQ-035 Load asserted in the cycle an event would occur -> no pulse on that edge; accumulator restarts at 0; next pulse follows the new configuration's schedule.
REQ-036 reset_ pulsed low while clk_out=1 in mode 1 -> clk_out 0 asynchronously; configuration returns to defaults; pulse schedule restarts as in REQ-031.
